// File: rtl/fpu_issue_ctrl_if.sv
// Handshake/bus bundle between the EX stage and the FPU issue controller.
// master = EX side (drives the op), slave = controller.
interface fpu_issue_ctrl_if;
    logic       op_valid;
    logic [4:0] op_sel;
    logic [4:0] op_rd;
    logic       flush;
    logic       fpu_start;
    logic [4:0] fpu_sel;
    logic       stall;
    logic       busy;
    logic       wb_valid;
    logic [4:0] wb_rd;
    logic       wb_int;
    logic       illegal_op;

    modport master (
        output op_valid, op_sel, op_rd, flush,
        input  fpu_start, fpu_sel, stall, busy,
        input  wb_valid, wb_rd, wb_int, illegal_op
    );

    modport slave (
        input  op_valid, op_sel, op_rd, flush,
        output fpu_start, fpu_sel, stall, busy,
        output wb_valid, wb_rd, wb_int, illegal_op
    );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// Issue/sequencing controller for the shared multi-cycle FPU.
// Optional FPU_PERF_CNT_EN adds a 32-bit stall-cycle counter port.
module fpu_issue_ctrl #(
    parameter int unsigned ADD_LAT = 3,
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned CVT_LAT = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    fpu_issue_ctrl_if.slave    bus
`ifdef FPU_PERF_CNT_EN
    ,
    output logic [31:0]        perf_stall_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_WB
    } state_t;

    state_t     r_state;
    logic [3:0] r_cnt;
    logic       r_fpu_start;
    logic [4:0] r_sel;
    logic [4:0] r_rd;
    logic       r_int;
    logic       r_wb_valid;
    logic       r_illegal;

    logic       w_legal;
    logic       w_can;
    logic       w_accept;
    logic [3:0] w_lat;
    logic       w_int;
    logic       w_is_add;
    logic       w_is_mul;
    logic       w_is_cvt;

    // Decode the incoming op: legality, latency and target regfile.
    always_comb begin
        w_legal  = (bus.op_sel >= 5'd4) && (bus.op_sel <= 5'd15);
        w_can    = (r_state == S_IDLE) || (r_state == S_WB);
        w_accept = w_can && bus.op_valid && w_legal && !bus.flush;
        w_is_add = (bus.op_sel == 5'd4) || (bus.op_sel == 5'd5);
        w_is_mul = (bus.op_sel == 5'd6);
        w_is_cvt = (bus.op_sel == 5'd14) || (bus.op_sel == 5'd15);
        w_lat    = 4'd1;
        unique case (1'b1)
            w_is_add: w_lat = 4'(ADD_LAT);
            w_is_mul: w_lat = 4'(MUL_LAT);
            w_is_cvt: w_lat = 4'(CVT_LAT);
            default:  w_lat = 4'd1;
        endcase
        w_int = (bus.op_sel == 5'd9)  ||
                (bus.op_sel == 5'd10) ||
                (bus.op_sel == 5'd11) ||
                (bus.op_sel == 5'd13) ||
                (bus.op_sel == 5'd15);
    end

    // Main FSM with registered start/writeback/illegal strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_fpu_start <= 1'b0;
            r_sel       <= 5'd0;
            r_rd        <= 5'd0;
            r_int       <= 1'b0;
            r_wb_valid  <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            r_fpu_start <= 1'b0;
            r_wb_valid  <= 1'b0;
            r_illegal   <= w_can && bus.op_valid && !w_legal;
            case (r_state)
                S_IDLE, S_WB: begin
                    if (w_accept) begin
                        r_sel       <= bus.op_sel;
                        r_rd        <= bus.op_rd;
                        r_int       <= w_int;
                        r_cnt       <= w_lat - 4'd1;
                        r_fpu_start <= 1'b1;
                        r_state     <= S_EXEC;
                    end else begin
                        r_state     <= S_IDLE;
                    end
                end
                S_EXEC: begin
                    if (bus.flush) begin
                        r_state    <= S_IDLE;
                    end else if (r_cnt == 4'd0) begin
                        r_state    <= S_WB;
                        r_wb_valid <= 1'b1;
                    end else begin
                        r_cnt      <= r_cnt - 4'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.stall      = w_accept || (r_state == S_EXEC);
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.fpu_start  = r_fpu_start;
    assign bus.fpu_sel    = r_sel;
    assign bus.wb_valid   = r_wb_valid;
    assign bus.wb_rd      = r_rd;
    assign bus.wb_int     = r_int;
    assign bus.illegal_op = r_illegal;

`ifdef FPU_PERF_CNT_EN
    logic [31:0] r_perf;

    // Count every cycle the pipeline is held; wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf <= 32'd0;
        end else if (bus.stall) begin
            r_perf <= r_perf + 32'd1;
        end
    end

    assign perf_stall_cnt = r_perf;
`endif

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Self-checking bench for fpu_issue_ctrl: vector table plus
// hand sequences for reset, back-to-back, flush and illegal ops.
module tb_fpu_issue_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fpu_issue_ctrl_if bus();

`ifdef FPU_PERF_CNT_EN
    logic [31:0] perf;
`endif

    fpu_issue_ctrl #(
        .ADD_LAT(3),
        .MUL_LAT(4),
        .CVT_LAT(2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef FPU_PERF_CNT_EN
        ,
        .perf_stall_cnt(perf)
`endif
    );

    typedef struct {
        logic [4:0] sel;
        logic [4:0] rd;
        int         lat;
        logic       wint;
    } vec_t;

    typedef struct {
        logic [4:0] rd;
        logic       wint;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present an op at the current negedge; it must be accepted now.
    task automatic issue(input logic [4:0] sel, input logic [4:0] rd,
                         input int lat, input logic wint);
        exp_t e;
        bus.op_valid = 1'b1;
        bus.op_sel   = sel;
        bus.op_rd    = rd;
        #1;
        chk("accept_stall", 32'(bus.stall), 32'd1);
        e.rd   = rd;
        e.wint = wint;
        e.lat  = lat;
        sb.push_back(e);
    endtask

    // Follow an accepted op to its writeback and score it.
    task automatic wait_wb(input logic [4:0] sel);
        int   n;
        exp_t e;
        @(negedge clk);
        bus.op_valid = 1'b0;
        chk("start_pulse", 32'(bus.fpu_start), 32'd1);
        chk("busy_exec", 32'(bus.busy), 32'd1);
        chk("fpu_sel", 32'(bus.fpu_sel), 32'(sel));
        n = 1;
        while (!bus.wb_valid && n < 40) begin
            @(negedge clk);
            n++;
            if (n == 2) chk("start_once", 32'(bus.fpu_start), 32'd0);
        end
        if (!bus.wb_valid) begin
            chk("wb_timeout", 32'd0, 32'd1);
        end else if (sb.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk("wb_latency", 32'(n), 32'(e.lat + 1));
            chk("wb_rd", 32'(bus.wb_rd), 32'(e.rd));
            chk("wb_int", 32'(bus.wb_int), 32'(e.wint));
            chk("wb_stall", 32'(bus.stall), 32'd0);
        end
    endtask

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{5'd4,  5'd7,  3, 1'b0};
        vecs[1]  = '{5'd5,  5'd1,  3, 1'b0};
        vecs[2]  = '{5'd6,  5'd2,  4, 1'b0};
        vecs[3]  = '{5'd9,  5'd3,  1, 1'b1};
        vecs[4]  = '{5'd10, 5'd4,  1, 1'b1};
        vecs[5]  = '{5'd13, 5'd5,  1, 1'b1};
        vecs[6]  = '{5'd14, 5'd6,  2, 1'b0};
        vecs[7]  = '{5'd15, 5'd8,  2, 1'b1};
        vecs[8]  = '{5'd8,  5'd9,  1, 1'b0};
        vecs[9]  = '{5'd7,  5'd10, 1, 1'b0};
        vecs[10] = '{5'd11, 5'd11, 1, 1'b1};
        vecs[11] = '{5'd12, 5'd12, 1, 1'b0};

        bus.op_valid = 1'b0;
        bus.op_sel   = 5'd0;
        bus.op_rd    = 5'd0;
        bus.flush    = 1'b0;

        #12;
        chk("reset_outs",
            32'({bus.fpu_start, bus.fpu_sel, bus.stall, bus.busy,
                 bus.wb_valid, bus.wb_rd, bus.wb_int, bus.illegal_op}),
            32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Add with rd=7; stall counter must read 4 afterwards.
        @(negedge clk);
        issue(5'd4, 5'd7, 3, 1'b0);
        wait_wb(5'd4);
`ifdef FPU_PERF_CNT_EN
        chk("perf_cnt", perf, 32'd4);
`endif
        @(negedge clk);
        chk("idle_after_wb", 32'(bus.busy), 32'd0);

        // Table of ops covering every legal latency class and regfile.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            issue(vecs[i].sel, vecs[i].rd, vecs[i].lat, vecs[i].wint);
            wait_wb(vecs[i].sel);
            @(negedge clk);
            chk("idle_after_wb", 32'(bus.busy), 32'd0);
        end

        // Back-to-back: add presented during the mul's WB cycle.
        @(negedge clk);
        issue(5'd6, 5'd2, 4, 1'b0);
        wait_wb(5'd6);
        issue(5'd4, 5'd13, 3, 1'b0);
        wait_wb(5'd4);
        @(negedge clk);
        chk("idle_after_b2b", 32'(bus.busy), 32'd0);

        // Flush on the second EXEC cycle of a mul.
        @(negedge clk);
        issue(5'd6, 5'd20, 4, 1'b0);
        void'(sb.pop_back());
        @(negedge clk);
        bus.op_valid = 1'b0;
        @(negedge clk);
        bus.flush = 1'b1;
        #1;
        chk("flush_cycle_stall", 32'(bus.stall), 32'd1);
        @(negedge clk);
        bus.flush = 1'b0;
        chk("flush_busy", 32'(bus.busy), 32'd0);
        chk("flush_stall", 32'(bus.stall), 32'd0);
        chk("flush_start", 32'(bus.fpu_start), 32'd0);
        for (int i = 0; i < 6; i++) begin
            chk("flush_no_wb", 32'(bus.wb_valid), 32'd0);
            @(negedge clk);
        end

        // Illegal op codes below and above the legal range.
        for (int i = 0; i < 2; i++) begin
            bus.op_valid = 1'b1;
            bus.op_sel   = (i == 0) ? 5'd2 : 5'd20;
            bus.op_rd    = 5'd1;
            #1;
            chk("illegal_stall", 32'(bus.stall), 32'd0);
            @(negedge clk);
            bus.op_valid = 1'b0;
            chk("illegal_pulse", 32'(bus.illegal_op), 32'd1);
            chk("illegal_busy", 32'(bus.busy), 32'd0);
            @(negedge clk);
            chk("illegal_once", 32'(bus.illegal_op), 32'd0);
        end

        // Reset asserted mid-EXEC of a mul.
        @(negedge clk);
        issue(5'd6, 5'd17, 4, 1'b0);
        void'(sb.pop_back());
        @(negedge clk);
        bus.op_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("reset_mid_exec",
            32'({bus.fpu_start, bus.fpu_sel, bus.stall, bus.busy,
                 bus.wb_valid, bus.wb_rd, bus.wb_int, bus.illegal_op}),
            32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("reset_no_wb", 32'(bus.wb_valid), 32'd0);
        end

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
